janus_cube: RTL and testbench

- MMIO-programmed 16x16 matrix-multiply (cube) accelerator control core. It sits on a 64-bit MMIO bus at base 0x8000_0000.
- Tracks L0A/L0B tile-buffer entry validity and latches one MATMUL instruction (M,K,N).
- On START it decodes the instruction into M·K·N tile micro-ops, queues them, issues them through a 3-stage compute pipeline, and raises done.
- Tile data values are not stored or computed; only control, sequencing and timing are modelled.

---
 rtl/janus_cube_pkg.sv | 48 ++++
 rtl/janus_cube_uop_fifo.sv | 69 ++++++
 rtl/janus_cube.sv | 257 +++++++++++++++++++++++++
 tb/tb_janus_cube.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/janus_cube_pkg.sv
// ---------------------------------------------------------------------------
// janus_cube_pkg
// Shared definitions for the janus_cube matrix-multiply control core:
//   - MMIO base and register addresses (64-bit bus, base 0x8000_0000)
//   - CONTROL register bit positions
//   - control FSM state encoding
//   - tile micro-op (uop) structure and index helpers
// ---------------------------------------------------------------------------
package janus_cube_pkg;

  localparam logic [63:0] CUBE_BASE    = 64'h0000_0000_8000_0000;
  localparam logic [63:0] ADDR_CONTROL = CUBE_BASE + 64'h0;
  localparam logic [63:0] ADDR_STATUS  = CUBE_BASE + 64'h8;
  localparam logic [63:0] ADDR_INST    = CUBE_BASE + 64'h10;
  localparam logic [63:0] ADDR_PERF    = CUBE_BASE + 64'h18;
  localparam logic [63:0] ADDR_L0A_LO  = CUBE_BASE + 64'h1000;
  localparam logic [63:0] ADDR_L0A_HI  = CUBE_BASE + 64'h4FFF;
  localparam logic [63:0] ADDR_L0B_LO  = CUBE_BASE + 64'h5000;
  localparam logic [63:0] ADDR_L0B_HI  = CUBE_BASE + 64'h8FFF;

  localparam int CTRL_START = 0;
  localparam int CTRL_RESET = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } cube_state_e;

  // One tile micro-op: tile coordinates plus the L0 entries it consumes.
  typedef struct packed {
    logic [11:0] m;
    logic [11:0] k;
    logic [11:0] n;
    logic [5:0]  a_idx;
    logic [5:0]  b_idx;
  } uop_t;

  // (outer * stride + inner) mod 64 -- the L0 entry a tile lives in.
  function automatic logic [5:0] l0_index(input logic [11:0] outer,
                                          input logic [11:0] stride,
                                          input logic [11:0] inner);
    logic [23:0] p;
    p = 24'(outer) * 24'(stride) + 24'(inner);
    return p[5:0];
  endfunction

endpackage

// File: rtl/janus_cube_uop_fifo.sv
// ---------------------------------------------------------------------------
// janus_cube_uop_fifo
// Synchronous FIFO with registered full/empty flags and a synchronous flush.
// Read data is the current head (show-ahead); pop advances it.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   flush             synchronous clear of contents and flags
//   push, din         write side (ignored when full)
//   pop, dout         read side (ignored when empty)
//   full, empty       registered occupancy flags
// ---------------------------------------------------------------------------
module janus_cube_uop_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count, count_next;
  logic             do_push, do_pop;

  assign do_push    = push && !full;
  assign do_pop     = pop && !empty;
  assign count_next = count + (AW+1)'(do_push) - (AW+1)'(do_pop);
  assign dout       = mem[rd_ptr];

  // NOTE: storage has no reset; the flags guarantee stale entries are never
  // read, and leaving it unreset lets it map onto plain RAM/flops cheaply.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      full  <= (count_next == (AW+1)'(DEPTH));
      empty <= (count_next == '0);
    end
  end

endmodule

// File: rtl/janus_cube.sv
// ---------------------------------------------------------------------------
// janus_cube
// MMIO-programmed 16x16 cube (matrix-multiply) accelerator control core.
// Tracks L0A/L0B entry validity, latches one MATMUL instruction, and on START
// decodes it into Mt*Kt*Nt tile uops (m outer, k middle, n inner), queues
// them, runs each through a PIPE_STAGES-deep compute pipeline and raises a
// sticky done when the last one retires. No tile data is modelled.
//
// Optional build macro: CUBE_PERF_CNT_EN -- adds a 64-bit RUN-cycle counter
// readable at offset 0x18 (reads 0 when the macro is undefined).
//
// Ports:
//   clk, rst_n              clock, async active-low reset
//   mem_wvalid/waddr/wdata  MMIO write beat (one per cycle)
//   mem_raddr/rdata         combinational MMIO read
//   done                    sticky completion flag
//   busy                    FSM in RUN
//   queue_full/queue_empty  registered uop FIFO flags
// ---------------------------------------------------------------------------
module janus_cube
  import janus_cube_pkg::*;
#(
  parameter int ARRAY_SIZE  = 16,
  parameter int L0_ENTRIES  = 64,
  parameter int QUEUE_DEPTH = 8,
  parameter int PIPE_STAGES = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_wvalid,
  input  logic [63:0] mem_waddr,
  input  logic [63:0] mem_wdata,
  input  logic [63:0] mem_raddr,
  output logic [63:0] mem_rdata,
  output logic        done,
  output logic        busy,
  output logic        queue_full,
  output logic        queue_empty
);

  localparam int TILE_SHIFT = $clog2(ARRAY_SIZE);
  localparam int PL         = PIPE_STAGES - 1;  // edges from issue to retire

  cube_state_e            state;
  logic [63:0]            inst_q;
  logic [L0_ENTRIES-1:0]  l0a_valid, l0b_valid;
  logic [11:0]            mt, kt, nt;
  logic                   u_zero;

  // MMIO write decode
  logic        wr_ctrl, start_go, soft_clr, wr_inst;
  logic        wr_l0a, wr_l0b;
  logic [63:0] l0a_rel, l0b_rel;

  // Decoder
  logic        dec_active;
  logic [11:0] dec_m, dec_k, dec_n;
  logic        dec_last;
  uop_t        dec_uop;
  logic        push;

  // FIFO / pipeline
  logic        pop;
  logic [35:0] fifo_dout;
  logic [11:0] head_m, head_k, head_n;
  logic        head_last;
  logic [PL-1:0] pipe_v, pipe_last;
  logic        retire, retire_last;
  logic [31:0] retired_cnt;

  // Tile counts are 12 bits wide; a dimension above 65520 wraps.
  assign mt     = 12'((17'(inst_q[15:0])  + 17'(ARRAY_SIZE - 1)) >> TILE_SHIFT);
  assign kt     = 12'((17'(inst_q[31:16]) + 17'(ARRAY_SIZE - 1)) >> TILE_SHIFT);
  assign nt     = 12'((17'(inst_q[47:32]) + 17'(ARRAY_SIZE - 1)) >> TILE_SHIFT);
  assign u_zero = (mt == '0) || (kt == '0) || (nt == '0);

  // ---------------------------------------------------------------------
  // Write decode. A soft reset in the same word overrides START.
  // ---------------------------------------------------------------------
  assign wr_ctrl  = mem_wvalid && (mem_waddr == ADDR_CONTROL);
  assign soft_clr = wr_ctrl && mem_wdata[CTRL_RESET];
  assign start_go = wr_ctrl && mem_wdata[CTRL_START] && !mem_wdata[CTRL_RESET]
                    && (state != ST_RUN);
  assign wr_inst  = mem_wvalid && (mem_waddr == ADDR_INST) && (state != ST_RUN);

  assign l0a_rel  = mem_waddr - ADDR_L0A_LO;
  assign l0b_rel  = mem_waddr - ADDR_L0B_LO;
  // Only the last element (row 15, col 15) of an entry marks it valid.
  assign wr_l0a   = mem_wvalid && (mem_waddr >= ADDR_L0A_LO) &&
                    (mem_waddr <= ADDR_L0A_HI) && (l0a_rel[7:0] == 8'hFF);
  assign wr_l0b   = mem_wvalid && (mem_waddr >= ADDR_L0B_LO) &&
                    (mem_waddr <= ADDR_L0B_HI) && (l0b_rel[7:0] == 8'hFF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l0a_valid <= '0;
      l0b_valid <= '0;
      inst_q    <= '0;
    end else if (soft_clr) begin
      l0a_valid <= '0;
      l0b_valid <= '0;
      inst_q    <= '0;
    end else begin
      if (wr_l0a)  l0a_valid[l0a_rel[13:8]] <= 1'b1;
      if (wr_l0b)  l0b_valid[l0b_rel[13:8]] <= 1'b1;
      if (wr_inst) inst_q <= mem_wdata;
    end
  end

  // ---------------------------------------------------------------------
  // Decoder: walks (m,k,n) and pushes one uop per cycle once both operand
  // entries are valid and the FIFO has room; otherwise holds its position.
  // ---------------------------------------------------------------------
  always_comb begin
    dec_uop.m     = dec_m;
    dec_uop.k     = dec_k;
    dec_uop.n     = dec_n;
    dec_uop.a_idx = l0_index(dec_m, kt, dec_k);
    dec_uop.b_idx = l0_index(dec_k, nt, dec_n);
  end

  assign dec_last = (dec_m == mt - 12'd1) && (dec_k == kt - 12'd1) &&
                    (dec_n == nt - 12'd1);
  assign push     = dec_active && !queue_full &&
                    l0a_valid[dec_uop.a_idx] && l0b_valid[dec_uop.b_idx];

  // ---------------------------------------------------------------------
  // Control FSM with decoder position and the sticky done flag.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      done       <= 1'b0;
      dec_active <= 1'b0;
      dec_m      <= '0;
      dec_k      <= '0;
      dec_n      <= '0;
    end else if (soft_clr) begin
      state      <= ST_IDLE;
      done       <= 1'b0;
      dec_active <= 1'b0;
      dec_m      <= '0;
      dec_k      <= '0;
      dec_n      <= '0;
    end else if (start_go) begin
      state      <= ST_RUN;
      done       <= 1'b0;
      dec_active <= !u_zero;
      dec_m      <= '0;
      dec_k      <= '0;
      dec_n      <= '0;
    end else begin
      if (state == ST_RUN && (u_zero || (retire && retire_last))) begin
        state <= ST_DONE;
        done  <= 1'b1;
      end
      if (push) begin
        if (dec_last) dec_active <= 1'b0;
        if (dec_n == nt - 12'd1) begin
          dec_n <= '0;
          if (dec_k == kt - 12'd1) begin
            dec_k <= '0;
            dec_m <= dec_m + 12'd1;
          end else begin
            dec_k <= dec_k + 12'd1;
          end
        end else begin
          dec_n <= dec_n + 12'd1;
        end
      end
    end
  end

  assign busy = (state == ST_RUN);

  // ---------------------------------------------------------------------
  // uop FIFO: carries tile coordinates so the pipeline can spot the final
  // tile. The operand indices were only needed for the decoder's check.
  // ---------------------------------------------------------------------
  assign pop = !queue_empty;

  janus_cube_uop_fifo #(
    .WIDTH (36),
    .DEPTH (QUEUE_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (soft_clr),
    .push  (push),
    .din   ({dec_uop.m, dec_uop.k, dec_uop.n}),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (queue_full),
    .empty (queue_empty)
  );

  assign {head_m, head_k, head_n} = fifo_dout;
  // The instruction cannot change during RUN, so mt/kt/nt are stable here.
  assign head_last = (head_m == mt - 12'd1) && (head_k == kt - 12'd1) &&
                     (head_n == nt - 12'd1);

  // ---------------------------------------------------------------------
  // Compute pipeline: a popped uop enters stage 1 and retires PL edges later.
  // ---------------------------------------------------------------------
  assign retire      = pipe_v[PL-1];
  assign retire_last = pipe_last[PL-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_v      <= '0;
      pipe_last   <= '0;
      retired_cnt <= '0;
    end else if (soft_clr) begin
      pipe_v      <= '0;
      pipe_last   <= '0;
      retired_cnt <= '0;
    end else begin
      pipe_v[0]    <= pop;
      pipe_last[0] <= pop && head_last;
      for (int i = 1; i < PL; i++) begin
        pipe_v[i]    <= pipe_v[i-1];
        pipe_last[i] <= pipe_last[i-1];
      end
      if (start_go)    retired_cnt <= '0;
      else if (retire) retired_cnt <= retired_cnt + 32'd1;
    end
  end

`ifdef CUBE_PERF_CNT_EN
  logic [63:0] perf_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    perf_cnt <= '0;
    else if (soft_clr || start_go) perf_cnt <= '0;
    else if (state == ST_RUN)      perf_cnt <= perf_cnt + 64'd1;
  end
`endif

  // ---------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------
  // NOTE: the default assignment first keeps this block latch-free for every
  // address that no case item covers.
  always_comb begin
    mem_rdata = '0;
    case (mem_raddr)
      ADDR_STATUS: mem_rdata = {retired_cnt, 28'd0, queue_full, queue_empty,
                                busy, done};
      ADDR_INST:   mem_rdata = inst_q;
`ifdef CUBE_PERF_CNT_EN
      ADDR_PERF:   mem_rdata = perf_cnt;
`endif
      default:     mem_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_janus_cube.sv
// ---------------------------------------------------------------------------
// tb_janus_cube
// Directed self-checking bench for janus_cube. Inputs change on the falling
// edge; outputs are sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_janus_cube;

  localparam logic [63:0] BASE   = 64'h8000_0000;
  localparam logic [63:0] A_CTRL = BASE + 64'h0;
  localparam logic [63:0] A_STAT = BASE + 64'h8;
  localparam logic [63:0] A_INST = BASE + 64'h10;
  localparam logic [63:0] A_PERF = BASE + 64'h18;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_wvalid;
  logic [63:0] mem_waddr, mem_wdata, mem_raddr, mem_rdata;
  logic        done, busy, queue_full, queue_empty;

  int tests_run = 0;
  int tests_failed = 0;

  janus_cube dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_wvalid  (mem_wvalid),
    .mem_waddr   (mem_waddr),
    .mem_wdata   (mem_wdata),
    .mem_raddr   (mem_raddr),
    .mem_rdata   (mem_rdata),
    .done        (done),
    .busy        (busy),
    .queue_full  (queue_full),
    .queue_empty (queue_empty)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before 2ms");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic mmio_write(input logic [63:0] a, input logic [63:0] d);
    @(negedge clk);
    mem_wvalid = 1'b1;
    mem_waddr  = a;
    mem_wdata  = d;
    @(posedge clk);
    #1;
    mem_wvalid = 1'b0;
  endtask

  task automatic mmio_read(input logic [63:0] a, output logic [63:0] d);
    mem_raddr = a;
    #1;
    d = mem_rdata;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Mark L0A/L0B entries [0..cnt-1] valid (row 15, col 15 writes).
  task automatic load_entries(input int cnt);
    for (int i = 0; i < cnt; i++) begin
      mmio_write(BASE + 64'h10FF + 64'(i) * 64'h100, 64'h0);
      mmio_write(BASE + 64'h50FF + 64'(i) * 64'h100, 64'h0);
    end
  endtask

  logic [63:0] rd;

  initial begin
    rst_n = 1'b0; mem_wvalid = 1'b0; mem_waddr = '0; mem_wdata = '0;
    mem_raddr = '0;
    step(2);
    rst_n = 1'b1;
    step(1);

    // ---- reset state ----
    check("rst_done", done, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_qfull", queue_full, 1'b0);
    check("rst_qempty", queue_empty, 1'b1);
    mmio_read(A_STAT, rd); check("rst_status", rd, 64'h4);
    mmio_read(A_INST, rd); check("rst_inst", rd, 64'h0);

    // ---- 16x16x16: U=1, done at S+4 ----
    load_entries(1);
    mmio_write(A_INST, 64'h0000_0010_0010_0010);
    mmio_read(A_INST, rd); check("inst_readback", rd, 64'h0000_0010_0010_0010);
    mmio_write(A_CTRL, 64'h1);                 // edge S
    check("s16_busy_at_S", busy, 1'b1);
    check("s16_done_at_S", done, 1'b0);
    step(3);
    check("s16_done_S+3", done, 1'b0);
    step(1);
    check("s16_done_S+4", done, 1'b1);
    check("s16_busy_S+4", busy, 1'b0);
    mmio_read(A_STAT, rd); check("s16_status", rd, 64'h0000_0001_0000_0005);
`ifdef CUBE_PERF_CNT_EN
    mmio_read(A_PERF, rd); check("s16_perf", rd, 64'd4);
`else
    mmio_read(A_PERF, rd); check("s16_perf_absent", rd, 64'd0);
`endif

    // ---- 32x32x32: U=8, done at S+11 ----
    load_entries(4);
    mmio_write(A_INST, 64'h0000_0020_0020_0020);
    mmio_write(A_CTRL, 64'h1);                 // edge S, from DONE
    check("s32_done_cleared", done, 1'b0);
    check("s32_busy_at_S", busy, 1'b1);
    step(10);
    check("s32_done_S+10", done, 1'b0);
    step(1);
    check("s32_done_S+11", done, 1'b1);
    check("s32_busy_after", busy, 1'b0);
    mmio_read(A_STAT, rd); check("s32_status", rd, 64'h0000_0008_0000_0005);

    // ---- 64x64x64: U=64, done at S+67 ----
    load_entries(16);
    mmio_write(A_INST, 64'h0000_0040_0040_0040);
    mmio_write(A_CTRL, 64'h1);
    step(66);
    check("s64_done_S+66", done, 1'b0);
    check("s64_busy_S+66", busy, 1'b1);
    step(1);
    check("s64_done_S+67", done, 1'b1);
    mmio_read(A_STAT, rd); check("s64_status", rd, 64'h0000_0040_0000_0005);

    // ---- soft reset from DONE clears everything ----
    mmio_write(A_CTRL, 64'h2);
    check("srst_done", done, 1'b0);
    mmio_read(A_STAT, rd); check("srst_status", rd, 64'h4);
    mmio_read(A_INST, rd); check("srst_inst", rd, 64'h0);

    // ---- stall: L0B[3] missing in 32^3 ----
    for (int i = 0; i < 4; i++)
      mmio_write(BASE + 64'h10FF + 64'(i) * 64'h100, 64'h0);
    for (int i = 0; i < 3; i++)
      mmio_write(BASE + 64'h50FF + 64'(i) * 64'h100, 64'h0);
    mmio_write(A_INST, 64'h0000_0020_0020_0020);
    mmio_write(A_CTRL, 64'h1);
    step(20);
    check("stall_busy", busy, 1'b1);
    check("stall_done", done, 1'b0);
    mmio_read(A_STAT, rd); check("stall_retired", rd[63:32], 64'd3);
    mmio_write(A_INST, 64'h0000_0001_0001_0001);   // ignored in RUN
    mmio_read(A_INST, rd); check("stall_inst_kept", rd, 64'h0000_0020_0020_0020);
    mmio_write(A_CTRL, 64'h1);                     // START ignored in RUN
    mmio_write(BASE + 64'h53FF, 64'h0);            // edge W
    step(7);
    check("stall_done_W+7", done, 1'b0);
    step(1);
    check("stall_done_W+8", done, 1'b1);
    mmio_read(A_STAT, rd); check("stall_status", rd, 64'h0000_0008_0000_0005);

    // ---- soft reset mid-RUN ----
    mmio_write(A_CTRL, 64'h1);
    step(3);
    check("midrun_busy", busy, 1'b1);
    mmio_write(A_CTRL, 64'h2);
    check("midrun_busy_clr", busy, 1'b0);
    check("midrun_done_clr", done, 1'b0);
    check("midrun_qempty", queue_empty, 1'b1);
    mmio_read(A_STAT, rd); check("midrun_status", rd, 64'h4);
    step(10);
    check("midrun_done_stays", done, 1'b0);

    // ---- non-final L0 element does not validate; START+RESET word ----
    mmio_write(BASE + 64'h10FF, 64'h0);
    mmio_write(BASE + 64'h50FE, 64'h0);            // col 14: no effect
    mmio_write(A_INST, 64'h0000_0010_0010_0010);
    mmio_write(A_CTRL, 64'h1);
    step(10);
    check("partial_busy", busy, 1'b1);
    check("partial_done", done, 1'b0);
    mmio_write(A_CTRL, 64'h3);                     // reset wins over start
    check("startreset_busy", busy, 1'b0);
    mmio_read(A_INST, rd); check("startreset_inst", rd, 64'h0);

    // ---- M=0: done at S+1 ----
    mmio_write(A_INST, 64'h0000_0010_0010_0000);
    mmio_write(A_CTRL, 64'h1);
    check("m0_busy_at_S", busy, 1'b1);
    check("m0_done_at_S", done, 1'b0);
    step(1);
    check("m0_done_S+1", done, 1'b1);
    check("m0_busy_S+1", busy, 1'b0);
    mmio_read(A_STAT, rd); check("m0_status", rd, 64'h5);

    // ---- unmapped accesses ----
    mmio_write(BASE + 64'h20, 64'hFFFF_FFFF);
    mmio_write(64'h9000_0000, 64'h1);
    mmio_read(BASE + 64'h20, rd); check("unmapped_rd", rd, 64'h0);
    mmio_read(A_CTRL, rd);        check("ctrl_rd_zero", rd, 64'h0);
    mmio_read(A_STAT, rd);        check("unmapped_no_effect", rd, 64'h5);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
